// File: rtl/seq_div_ctrl_pkg.sv
// Shared types and constants for the restoring-division sequencer.
package seq_div_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width: must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_div_ctrl_if.sv
// Start/busy/done request interface with operand and result buses.
interface seq_div_ctrl_if #(
  parameter int unsigned WIDTH = seq_div_ctrl_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requesting logic
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_ctrl_div_sub_step.sv
// Combinational (WIDTH+1)-bit ripple subtractor: trial = shifted + ~{0,d} + 1.
module div_sub_step
  import seq_div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   trial_c,
  output logic             no_borrow_c
);

  logic [WIDTH+1:0] carry;
  logic [WIDTH:0]   b_n;

  // Full-adder ripple chain with carry-in 1; carry-out 1 means no borrow.
  always_comb begin
    b_n      = ~{1'b0, d};
    carry    = '0;
    carry[0] = 1'b1;
    trial_c  = '0;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      trial_c[i]   = shifted[i] ^ b_n[i] ^ carry[i];
      carry[i+1]   = (shifted[i] & b_n[i]) | (shifted[i] & carry[i]) | (b_n[i] & carry[i]);
    end
    no_borrow_c = carry[WIDTH+1];
  end

endmodule

// File: rtl/seq_div_ctrl.sv
// Restoring unsigned divider controller: one trial subtraction per clock.
module seq_div_ctrl
  import seq_div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_div_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic             unused_guard;

  // R never exceeds D-1 between steps, so its guard bit is only carried along.
  assign unused_guard = r_q[WIDTH];
  assign shifted      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_sub (
    .shifted     (shifted),
    .d           (d_q),
    .trial_c     (trial),
    .no_borrow_c (no_borrow)
  );

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, iteration step and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          d_d   = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = no_borrow ? trial : shifted;
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Scoreboard bench for seq_div_ctrl: directed cases plus randomized operands.
module tb_seq_div_ctrl;
  import seq_div_ctrl_pkg::*;

  localparam int unsigned W = DEF_WIDTH;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_div_ctrl_if #(.WIDTH(W)) bus();

  seq_div_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic exp_t model(input int unsigned a, input int unsigned b);
    exp_t e;
    if (b == 0) begin
      e.q   = {W{1'b1}};
      e.r   = W'(a);
      e.dbz = 1'b1;
    end else begin
      e.q   = W'(a / b);
      e.r   = W'(a % b);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare results whenever done is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_and_done", 32'(bus.busy & bus.done), 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", 32'(bus.quotient), 32'(e.q));
          check("remainder", 32'(bus.remainder), 32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        end
      end
    end
  end

  // Drive a start for one edge from a negedge; operands then scrambled.
  task automatic issue(input int unsigned a, input int unsigned b, input bit push);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    if (push) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  // Wait (bounded) for done; optionally check latency and busy cycle count.
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int n  = 0;
    int nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) nb++;
    end while (!bus.done && n < 64);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end else if (exp_lat >= 0) begin
      check("latency", n, exp_lat);
      check("busy_cycles", nb, exp_busy);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_quotient"}, 32'(bus.quotient), 0);
    check({tag, "_remainder"}, 32'(bus.remainder), 0);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");

    // Directed cases
    issue(200, 7, 1);   wait_done(W + 1, W);
    @(negedge clk); issue(255, 1, 1);   wait_done(W + 1, W);
    @(negedge clk); issue(5, 9, 1);     wait_done(W + 1, W);
    @(negedge clk); issue(255, 255, 1); wait_done(W + 1, W);
    @(negedge clk); issue(100, 0, 1);   wait_done(1, 0);

    // start during RUN must be ignored
    @(negedge clk);
    issue(200, 7, 1);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(3);
    bus.divisor  = W'(2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(-1, -1);

    // Back-to-back start in the DONE cycle
    issue(9, 4, 1);
    wait_done(W + 1, W);

    // Reset mid-run aborts the operation
    @(negedge clk);
    issue(50, 3, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("post_abort");
    issue(50, 3, 1);
    wait_done(W + 1, W);

    // Randomized operands, mixing idle gaps and back-to-back starts
    for (int k = 0; k < 24; k++) begin
      int unsigned a;
      int unsigned b;
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(a, b, 1);
      wait_done((b == 0) ? 1 : int'(W) + 1, (b == 0) ? 0 : int'(W));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
